// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Owns the program counter and walks it through instruction fetch. One
//   request at a time goes to instruction memory over a req/ack handshake.
//   The returned word is captured and offered to decode over a valid/ready
//   handshake. Supports start, graceful halt at an instruction boundary, and
//   an automatic stop once the instruction at LAST_ADDR has been delivered.
//
// Parameters:
//   AW        PC / fetch address width
//   DW        instruction width
//   LAST_ADDR address of the final program instruction (must be < 2**AW)
//   TIMEOUT   REQ cycles without ack before ERR (1..255, timeout build only)
//
// Ports:
//   i_clk          clock, all logic on rising edge
//   i_reset        synchronous active-low reset (0 = reset)
//   i_start        begin fetching at address 0 (IDLE, DONE, ERR only)
//   i_halt_req     one-cycle pulse, stop at the next instruction boundary
//   o_imem_req     fetch request, held until acknowledged
//   o_imem_addr    fetch address (the PC)
//   i_imem_ack     memory returns data this cycle
//   i_imem_rdata   instruction data, valid with i_imem_ack
//   o_instr_valid  captured instruction available to decode
//   i_instr_ready  decode accepts the instruction
//   o_instr        captured instruction
//   o_instr_pc     address the captured instruction came from
//   o_busy         fetching or presenting an instruction
//   o_done         program completed
//   o_err          fetch timed out (always 0 without FETCH_TIMEOUT_EN)
//
// Build option:
//   FETCH_TIMEOUT_EN  when defined, a request that goes TIMEOUT cycles
//                     without ack parks the sequencer in ERR.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int AW        = 6,
  parameter int DW        = 32,
  parameter int LAST_ADDR = 63,
  parameter int TIMEOUT   = 15
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_halt_req,
  output logic          o_imem_req,
  output logic [AW-1:0] o_imem_addr,
  input  logic          i_imem_ack,
  input  logic [DW-1:0] i_imem_rdata,
  output logic          o_instr_valid,
  input  logic          i_instr_ready,
  output logic [DW-1:0] o_instr,
  output logic [AW-1:0] o_instr_pc,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  // Catch impossible configurations at elaboration rather than in silicon.
  if (LAST_ADDR < 0 || LAST_ADDR >= (1 << AW)) begin : g_bad_last_addr
    $error("fetch_sequencer: LAST_ADDR must lie in 0 .. 2**AW-1");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fetch_sequencer: TIMEOUT must lie in 1 .. 255");
  end

  localparam logic [AW-1:0] LAST_PC = AW'(LAST_ADDR);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_OUT  = 3'd2,
    S_DONE = 3'd3
`ifdef FETCH_TIMEOUT_EN
    ,
    S_ERR  = 3'd4
`endif
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_pc;
  logic [AW-1:0]   w_pc_next;
  logic            r_halt_pend;
  logic            w_halt_pend_next;
  logic [DW-1:0]   r_instr;
  logic [AW-1:0]   r_instr_pc;
  logic            w_capture;
  logic            w_launch;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]      r_tcount;
  logic [7:0]      w_tcount_next;
`endif

  // A start is only meaningful when nothing is in flight; IDLE, DONE and
  // ERR all restart the program from address 0 the same way.
  always_comb begin
    w_launch = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: w_launch = i_start;
`ifdef FETCH_TIMEOUT_EN
      S_ERR:          w_launch = i_start;
`endif
      default:        w_launch = 1'b0;
    endcase
  end

  // Next-state logic. The halt request is remembered while a fetch is in
  // flight so the current instruction is still delivered, and it is acted
  // on at the decode handshake. Reaching the last address outranks a halt
  // so a program that finishes always reports done.
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_halt_pend_next = r_halt_pend;
    w_capture        = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    w_tcount_next    = r_tcount;
`endif

    if (w_launch) begin
      w_state_next     = S_REQ;
      w_pc_next        = '0;
      w_halt_pend_next = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      w_tcount_next    = '0;
`endif
    end else begin
      case (r_state)
        S_REQ: begin
          if (i_halt_req) begin
            w_halt_pend_next = 1'b1;
          end
          if (i_imem_ack) begin
            w_capture    = 1'b1;
            w_state_next = S_OUT;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_tcount == TMO_LAST) begin
            w_state_next = S_ERR;
          end else begin
            w_tcount_next = r_tcount + 8'd1;
          end
`endif
        end

        S_OUT: begin
          if (i_instr_ready) begin
            if (r_pc == LAST_PC) begin
              w_state_next     = S_DONE;
              w_halt_pend_next = 1'b0;
            end else if (r_halt_pend || i_halt_req) begin
              w_state_next     = S_IDLE;
              w_halt_pend_next = 1'b0;
            end else begin
              w_state_next  = S_REQ;
              w_pc_next     = r_pc + AW'(1);
`ifdef FETCH_TIMEOUT_EN
              w_tcount_next = '0;
`endif
            end
          end else if (i_halt_req) begin
            w_halt_pend_next = 1'b1;
          end
        end

        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  // State, PC and the captured instruction. Reset wins over everything, so
  // an ack that lands after reset finds the sequencer idle and is ignored.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_halt_pend <= 1'b0;
      r_instr     <= '0;
      r_instr_pc  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_halt_pend <= w_halt_pend_next;
      if (w_capture) begin
        r_instr    <= i_imem_rdata;
        r_instr_pc <= r_pc;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Counts REQ cycles that went by without an ack for the current request.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_tcount <= '0;
    end else begin
      r_tcount <= w_tcount_next;
    end
  end
`endif

  // Every output is a decode of registered state, so nothing on an input
  // can ripple straight through to an output in the same cycle.
  assign o_imem_req    = (r_state == S_REQ);
  assign o_imem_addr   = r_pc;
  assign o_instr_valid = (r_state == S_OUT);
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_busy        = (r_state == S_REQ) || (r_state == S_OUT);
  assign o_done        = (r_state == S_DONE);
`ifdef FETCH_TIMEOUT_EN
  assign o_err         = (r_state == S_ERR);
`else
  assign o_err         = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. A behavioural model tracks the
// program at transaction level (which address is being fetched, whether an
// instruction is waiting for decode, whether a halt has been asked for) and
// every cycle the DUT outputs are compared with it. A short table of
// hand-written vectors, directed sequences for the multi-cycle corner cases
// and a randomized run all drive the same model.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int LAST = 63;
  localparam int TMO  = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start;
  logic          halt;
  logic          ack;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          imemReq;
  logic [AW-1:0] imemAddr;
  logic          instrValid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instrPc;
  logic          busy;
  logic          done;
  logic          err;

  logic [DW-1:0] mem [0:LAST];

  int testsRun    = 0;
  int testsFailed = 0;

  // Clock generation, 10 time-unit period.
  always #5 clk = ~clk;

  // Instruction memory contents follow the requested address.
  assign rdata = mem[imemAddr];

  fetch_sequencer #(
    .AW       (AW),
    .DW       (DW),
    .LAST_ADDR(LAST),
    .TIMEOUT  (TMO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rstN),
    .i_start      (start),
    .i_halt_req   (halt),
    .o_imem_req   (imemReq),
    .o_imem_addr  (imemAddr),
    .i_imem_ack   (ack),
    .i_imem_rdata (rdata),
    .o_instr_valid(instrValid),
    .i_instr_ready(ready),
    .o_instr      (instr),
    .o_instr_pc   (instrPc),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  // Model of where the program stands: waiting, fetching, presenting,
  // finished, or stuck on a fetch that never came back.
  typedef enum {P_IDLE, P_FETCH, P_PRESENT, P_FINISHED, P_STUCK} phase_t;

  phase_t        phase;
  int            mPc;
  bit            mHalt;
  int            mWait;
  logic [DW-1:0] mInstr;
  int            mIpc;

  typedef struct {
    bit st;
    bit hl;
    bit ak;
    bit rd;
    bit eReq;
    int eAddr;
    bit eValid;
    int eIpc;
    bit eBusy;
    bit eDone;
  } vec_t;

  vec_t vecs [18];

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input string fld,
                             input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s %s: got %0h expected %0h", tag, fld, act, exp);
    end
  endtask

  // Compare every DUT output with what the model says should be visible.
  task automatic checkAll(input string tag);
    checkOutput(tag, "imem_req",    32'(imemReq),    32'(phase == P_FETCH));
    checkOutput(tag, "imem_addr",   32'(imemAddr),   32'(mPc));
    checkOutput(tag, "instr_valid", 32'(instrValid), 32'(phase == P_PRESENT));
    checkOutput(tag, "busy",        32'(busy),
                32'(phase == P_FETCH || phase == P_PRESENT));
    checkOutput(tag, "done",        32'(done),       32'(phase == P_FINISHED));
    checkOutput(tag, "err",         32'(err),        32'(phase == P_STUCK));
    checkOutput(tag, "instr",       instr,           mInstr);
    checkOutput(tag, "instr_pc",    32'(instrPc),    32'(mIpc));
  endtask

  // Advance the model by one clock given the inputs applied for that clock.
  task automatic modelStep(input bit st, input bit hl, input bit ak, input bit rd);
    if (st && (phase == P_IDLE || phase == P_FINISHED || phase == P_STUCK)) begin
      phase = P_FETCH;
      mPc   = 0;
      mHalt = 0;
      mWait = 0;
    end else if (phase == P_FETCH) begin
      if (hl) mHalt = 1;
      if (ak) begin
        mInstr = mem[mPc];
        mIpc   = mPc;
        phase  = P_PRESENT;
      end else begin
        mWait++;
`ifdef FETCH_TIMEOUT_EN
        if (mWait >= TMO) phase = P_STUCK;
`endif
      end
    end else if (phase == P_PRESENT) begin
      if (rd) begin
        if (mPc == LAST) begin
          phase = P_FINISHED;
        end else if (mHalt || hl) begin
          phase = P_IDLE;
          mHalt = 0;
        end else begin
          mPc   = mPc + 1;
          mWait = 0;
          phase = P_FETCH;
        end
      end else if (hl) begin
        mHalt = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, let the clock go, then compare #1 later.
  task automatic applyStimulus(input bit st, input bit hl, input bit ak, input bit rd,
                               input string tag);
    start = st;
    halt  = hl;
    ack   = ak;
    ready = rd;
    modelStep(st, hl, ak, rd);
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  // Hold reset low for n edges and check the cleared state.
  task automatic doReset(input int n);
    rstN  = 1'b0;
    start = 1'b0;
    halt  = 1'b0;
    ack   = 1'b0;
    ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    phase  = P_IDLE;
    mPc    = 0;
    mHalt  = 0;
    mWait  = 0;
    mInstr = '0;
    mIpc   = 0;
    checkAll("reset");
    rstN = 1'b1;
  endtask

  // Run with immediate acks and ready until the model is fetching addr.
  task automatic runTo(input int addr, input string tag);
    int n;
    n = 0;
    while (!(phase == P_FETCH && mPc == addr) && n < 300) begin
      applyStimulus(0, 0, 1, 1, tag);
      n++;
    end
  endtask

  initial begin
    int reqCnt;
    int stall;
    bit ak;
    bit rd;

    for (int i = 0; i <= LAST; i++) mem[i] = $urandom;

    vecs[0]  = '{1,0,0,0, 1,0,0,0,1,0};
    vecs[1]  = '{0,0,1,0, 0,0,1,0,1,0};
    vecs[2]  = '{0,0,0,0, 0,0,1,0,1,0};
    vecs[3]  = '{0,0,0,1, 1,1,0,0,1,0};
    vecs[4]  = '{0,0,0,0, 1,1,0,0,1,0};
    vecs[5]  = '{0,1,0,0, 1,1,0,0,1,0};
    vecs[6]  = '{0,0,1,0, 0,1,1,1,1,0};
    vecs[7]  = '{0,0,0,1, 0,1,0,1,0,0};
    vecs[8]  = '{0,1,0,0, 0,1,0,1,0,0};
    vecs[9]  = '{1,1,0,0, 1,0,0,1,1,0};
    vecs[10] = '{0,0,1,1, 0,0,1,0,1,0};
    vecs[11] = '{0,1,0,1, 0,0,0,0,0,0};
    vecs[12] = '{1,0,0,0, 1,0,0,0,1,0};
    vecs[13] = '{0,0,1,0, 0,0,1,0,1,0};
    vecs[14] = '{0,0,0,1, 1,1,0,0,1,0};
    vecs[15] = '{1,0,0,0, 1,1,0,0,1,0};
    vecs[16] = '{1,0,1,0, 0,1,1,1,1,0};
    vecs[17] = '{0,0,0,1, 1,2,0,1,1,0};

    // Table of hand-derived cycles: handshakes, halt, ignored start.
    doReset(2);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].st, vecs[i].hl, vecs[i].ak, vecs[i].rd, "vec");
      checkOutput($sformatf("vec%0d", i), "req",   32'(imemReq),    32'(vecs[i].eReq));
      checkOutput($sformatf("vec%0d", i), "addr",  32'(imemAddr),   32'(vecs[i].eAddr));
      checkOutput($sformatf("vec%0d", i), "valid", 32'(instrValid), 32'(vecs[i].eValid));
      checkOutput($sformatf("vec%0d", i), "ipc",   32'(instrPc),    32'(vecs[i].eIpc));
      checkOutput($sformatf("vec%0d", i), "busy",  32'(busy),       32'(vecs[i].eBusy));
      checkOutput($sformatf("vec%0d", i), "done",  32'(done),       32'(vecs[i].eDone));
      if (vecs[i].eValid)
        checkOutput($sformatf("vec%0d", i), "instr", instr, mem[vecs[i].eIpc]);
    end

    // Full program, ack in the first request cycle, decode always ready:
    // two cycles per instruction, done after address LAST.
    doReset(2);
    applyStimulus(1, 0, 0, 0, "full");
    for (int i = 0; i < 2 * (LAST + 1); i++) applyStimulus(0, 0, 1, 1, "full");
    checkOutput("full_end", "done",     32'(done),    32'd1);
    checkOutput("full_end", "imem_req", 32'(imemReq), 32'd0);
    checkOutput("full_end", "addr",     32'(imemAddr), 32'(LAST));

    // Slow memory plus a decode stall at address 5.
    applyStimulus(1, 0, 0, 0, "stall");
    reqCnt = 0;
    stall  = 0;
    for (int n = 0; n < 200 && !(phase == P_FETCH && mPc == 7); n++) begin
      if (phase == P_FETCH) begin
        ak     = (reqCnt == 3);
        reqCnt = ak ? 0 : reqCnt + 1;
        applyStimulus(0, 0, ak, 0, "stall");
      end else begin
        rd = !(mPc == 5 && stall < 4);
        if (!rd) stall++;
        applyStimulus(0, 0, 0, rd, "stall");
      end
    end
    checkOutput("stall_end", "addr", 32'(imemAddr), 32'd7);

    // Halt during the request for address 10.
    doReset(1);
    applyStimulus(1, 0, 0, 0, "halt");
    runTo(10, "halt");
    applyStimulus(0, 1, 0, 1, "halt");
    applyStimulus(0, 0, 1, 1, "halt");
    checkOutput("halt_deliver", "instr_pc", 32'(instrPc), 32'd10);
    applyStimulus(0, 0, 0, 1, "halt");
    checkOutput("halt_stop", "busy", 32'(busy),     32'd0);
    checkOutput("halt_stop", "addr", 32'(imemAddr), 32'd10);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, "halt_idle");
    applyStimulus(1, 0, 0, 0, "halt_restart");
    checkOutput("halt_restart", "req",  32'(imemReq),  32'd1);
    checkOutput("halt_restart", "addr", 32'(imemAddr), 32'd0);

    // Reset in the middle of the request for address 20, ack arrives late.
    runTo(20, "midreset");
    doReset(1);
    checkOutput("midreset", "req",  32'(imemReq),  32'd0);
    checkOutput("midreset", "addr", 32'(imemAddr), 32'd0);
    applyStimulus(0, 0, 1, 1, "lateack");
    applyStimulus(0, 0, 1, 1, "lateack");
    checkOutput("lateack", "valid", 32'(instrValid), 32'd0);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers address 7, then recovery, then ack on the limit.
    applyStimulus(1, 0, 0, 0, "tmo");
    runTo(7, "tmo");
    for (int i = 0; i < TMO; i++) applyStimulus(0, 0, 0, 1, "tmo");
    checkOutput("tmo", "err",  32'(err),      32'd1);
    checkOutput("tmo", "req",  32'(imemReq),  32'd0);
    checkOutput("tmo", "addr", 32'(imemAddr), 32'd7);
    applyStimulus(1, 0, 0, 0, "tmo_recover");
    checkOutput("tmo_recover", "addr", 32'(imemAddr), 32'd0);
    runTo(7, "tmo_recover");
    for (int i = 0; i < TMO - 1; i++) applyStimulus(0, 0, 0, 1, "tmo_edge");
    applyStimulus(0, 0, 1, 1, "tmo_edge");
    checkOutput("tmo_edge", "err",   32'(err),        32'd0);
    checkOutput("tmo_edge", "valid", 32'(instrValid), 32'd1);
`endif

    // Randomized traffic: random acks, decode stalls, halts and starts.
    doReset(1);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 20) == 0, ($urandom % 12) == 0,
                    ($urandom % 3) == 0, ($urandom % 3) != 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the 6-bit program counter through instruction fetch.
- Owns the PC register and issues one request at a time to an instruction memory over a req/ack handshake.
- Presents each fetched instruction to decode over a valid/ready handshake.
- Supports start, graceful halt at an instruction boundary, and automatic stop after the last program address.

Parameters:
AW, 6, PC/address width
DW, 32, instruction width
LAST_ADDR, 63, address of last instruction; must be < 2^AW
TIMEOUT, 15, max REQ cycles without ack (used only with FETCH_TIMEOUT_EN); range 1..255

Ports:
CLK  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge CLK)
start  in  1  begin fetching from address 0; honoured only in IDLE, DONE, ERR
halt_req  in  1  one-cycle pulse; stop at next instruction boundary
imem_req  out  1  fetch request; held until ack
imem_addr  out  AW  fetch address (= PC)
imem_ack  in  1  memory returns data; valid only while imem_req=1
imem_rdata  in  DW  instruction data, valid with imem_ack
instr_valid  out  1  instruction available to decode
instr_ready  in  1  decode accepts
instr  out  DW  captured instruction
instr_pc  out  AW  address of instr
busy  out  1  state is REQ or OUT
done  out  1  program completed (state DONE)
err  out  1  fetch timeout (state ERR); tied 0 when feature is out

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE, pc=0, halt_pend=0.
  - instr, instr_pc, timeout count cleared.
  - All outputs 0 from the cycle after the reset edge.
  - Reset overrides every other input, including mid-fetch. An ack arriving after reset is ignored.
- All outputs are decoded from registered state/registers. No combinational input-to-output paths.
- IDLE:
  - On start=1: pc=0, go to REQ.
  - halt_req is ignored.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1: capture instr<=imem_rdata and instr_pc<=pc, go to OUT.
  - Minimum latency is 1 cycle (ack during the first REQ cycle). An ack that is not accepted has no effect.
- OUT:
  - instr_valid=1. instr and instr_pc are stable until the handshake.
  - On instr_valid & instr_ready, evaluate in priority order:
    1. pc==LAST_ADDR: go to DONE.
    2. halt_pend or halt_req: go to IDLE; clear halt_pend; pc holds.
    3. Otherwise: pc<=pc+1, go to REQ.
  - Result: one request per instruction; at best 2 cycles per instruction.
- DONE:
  - done=1.
  - On start=1: pc=0, clear done, go to REQ.
- halt_req:
  - In REQ/OUT it sets sticky halt_pend.
  - The in-flight fetch completes and is delivered before the halt takes effect.
  - Simultaneous halt_req and handshake in OUT halts at that boundary.
- start:
  - Ignored while busy.
  - start and halt_req in the same IDLE cycle: start wins, halt ignored.
- PC arithmetic:
  - AW-bit unsigned.
  - No wrap is ever reached, because DONE occurs at LAST_ADDR. With LAST_ADDR=2^AW-1 the increment never executes.
- busy = (state==REQ or OUT). done, busy and err are mutually exclusive.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on REQ entry and increments on each REQ cycle without ack.
  - When the count reaches TIMEOUT without ack, the next state is ERR: err=1, imem_req=0, pc holds the failing address.
  - ERR is left only on start (pc=0, go to REQ) or reset.
  - Ack in the same cycle the limit is reached is accepted; no error.
- Not defined:
  - No counter, no ERR state.
  - REQ waits indefinitely.
  - err is tied to 0.

Test Plan:
1. Reset low 2 cycles, then start pulse; memory acks after 1 cycle; instr_ready=1 always -> imem_addr 0,1,2,... each delivered with matching instr_pc; instr equals memory contents; after address 63, done=1 and imem_req=0.
2. Memory ack delay 3 cycles; instr_ready low for 4 cycles on address 5 -> instr_valid held, instr/instr_pc stable; imem_req stays 0 until handshake; next request addr 6.
3. halt_req pulse during REQ for address 10 -> address 10 delivered; state IDLE with busy=0 and pc=10; no request for 11; subsequent start restarts from 0.
4. reset driven low while in REQ at address 20, memory acks one cycle later -> all outputs 0 after the reset edge; late ack ignored; no instr_valid.
5. (FETCH_TIMEOUT_EN, TIMEOUT=4) memory never acks address 7 -> err=1 after 4 REQ cycles; imem_req=0; start recovers with fetch from 0. Repeat with ack on the 4th cycle -> no error.
